// File: rtl/lifo_fifo_buffer.sv
// Single-port buffer with run-time LIFO/FIFO ordering, occupancy count, push+pop,
// and overflow/underflow pulses. All outputs come from registers.
module lifo_fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode_in,
  input  logic [1:0]            op_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  mode
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_WIDTH-1:0]  r_count;
  logic [PTR_WIDTH-1:0]  r_rd_ptr, r_wr_ptr;
  logic                  r_mode;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid, r_overflow, r_underflow;

  logic                  w_empty, w_full, w_mode;
  logic [CNT_WIDTH-1:0]  w_count_d;
  logic [PTR_WIDTH-1:0]  w_rd_ptr_d, w_wr_ptr_d, w_raddr, w_waddr, w_top, w_rd_nxt, w_wr_nxt;
  logic                  w_we, w_re, w_bypass, w_ovf, w_unf;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_WIDTH'(DEPTH));
  // While empty the requested mode takes effect for this very operation, so the
  // first stored word is placed consistently with the ordering that will read it.
  assign w_mode   = w_empty ? mode_in : r_mode;
  assign w_top    = PTR_WIDTH'(r_count - 1'b1);
  assign w_rd_nxt = (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_nxt = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;

  always_comb begin
    w_count_d  = r_count;
    w_rd_ptr_d = r_rd_ptr;
    w_wr_ptr_d = r_wr_ptr;
    w_raddr    = '0;
    w_waddr    = '0;
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_bypass   = 1'b0;
    w_ovf      = 1'b0;
    w_unf      = 1'b0;
    if (!reset) begin
      unique case (op_in)
        2'b01: begin
          if (w_empty) begin
            w_unf = 1'b1;
          end else begin
            w_re      = 1'b1;
            w_count_d = r_count - 1'b1;
          end
        end
        2'b10: begin
          if (w_full) begin
            w_ovf = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_count_d = r_count + 1'b1;
          end
        end
        2'b11: begin
          if (w_empty) begin
            w_bypass = 1'b1;
          end else begin
            w_re = 1'b1;
            w_we = 1'b1;
          end
        end
        default: ;
      endcase

      if (w_mode) begin
        w_raddr = r_rd_ptr;
        w_waddr = r_wr_ptr;
        if (w_re) w_rd_ptr_d = w_rd_nxt;
        if (w_we) w_wr_ptr_d = w_wr_nxt;
      end else begin
        w_raddr = w_top;
        // Push+pop on a stack replaces the top in place.
        w_waddr = w_re ? w_top : PTR_WIDTH'(r_count);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_mode       <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_count      <= w_count_d;
      r_rd_ptr     <= w_rd_ptr_d;
      r_wr_ptr     <= w_wr_ptr_d;
      r_mode       <= w_mode;
      r_data_valid <= w_re | w_bypass;
      r_overflow   <= w_ovf;
      r_underflow  <= w_unf;
      if (w_re) begin
        r_data_out <= r_mem[w_raddr];
      end else if (w_bypass) begin
        r_data_out <= data_in;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign empty      = w_empty;
  assign full       = w_full;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign mode       = r_mode;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Bench for lifo_fifo_buffer: directed vector table, then randomized traffic
// checked against a queue-based reference model.
module tb_lifo_fifo_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = DW + CW + 6;

  logic          clk = 1'b0;
  logic          reset, mode_in;
  logic [1:0]    op_in;
  logic [DW-1:0] data_in, data_out;
  logic          data_valid, empty, full, overflow, underflow, mode;
  logic [CW-1:0] count;

  lifo_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_in    (mode_in),
    .op_in      (op_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          mi;
    logic [1:0]    op;
    logic [DW-1:0] din;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: the buffer as an ordered list, oldest word first.
  logic [DW-1:0] mq[$];
  logic          m_mode;
  logic [DW-1:0] m_dout;

  function automatic logic [OW-1:0] pack(input logic [DW-1:0] dout, input logic dv,
                                         input logic emp, input logic fl, input int cnt,
                                         input logic ovf, input logic unf, input logic md);
    return {dout, dv, emp, fl, CW'(cnt), ovf, unf, md};
  endfunction

  function automatic void add(input logic rst, input logic mi, input logic [1:0] op,
                              input logic [DW-1:0] din, input logic [DW-1:0] dout,
                              input logic dv, input logic emp, input logic fl, input int cnt,
                              input logic ovf, input logic unf, input logic md);
    vec_t v;
    v.rst = rst;
    v.mi  = mi;
    v.op  = op;
    v.din = din;
    v.exp = pack(dout, dv, emp, fl, cnt, ovf, unf, md);
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic rst, input logic mi, input logic [1:0] op,
                       input logic [DW-1:0] din);
    reset   = rst;
    mode_in = mi;
    op_in   = op;
    data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [OW-1:0] exp);
    logic [OW-1:0] act;
    act = {data_out, data_valid, empty, full, count, overflow, underflow, mode};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {dout,dv,emp,full,cnt,ovf,unf,mode}=%h, expected %h",
               name, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic mi, input logic [1:0] op,
                            input logic [DW-1:0] din, output logic [OW-1:0] exp);
    logic dv, ovf, unf, eff;
    dv  = 1'b0;
    ovf = 1'b0;
    unf = 1'b0;
    if (rst) begin
      mq.delete();
      m_mode = 1'b0;
      m_dout = '0;
    end else begin
      eff    = (mq.size() == 0) ? mi : m_mode;
      m_mode = eff;
      case (op)
        2'b01: begin
          if (mq.size() == 0) unf = 1'b1;
          else begin
            m_dout = eff ? mq.pop_front() : mq.pop_back();
            dv     = 1'b1;
          end
        end
        2'b10: begin
          if (mq.size() == DEPTH) ovf = 1'b1;
          else mq.push_back(din);
        end
        2'b11: begin
          dv = 1'b1;
          if (mq.size() == 0) m_dout = din;
          else if (eff) begin
            m_dout = mq.pop_front();
            mq.push_back(din);
          end else begin
            m_dout = mq[mq.size() - 1];
            mq[mq.size() - 1] = din;
          end
        end
        default: ;
      endcase
    end
    exp = pack(m_dout, dv, mq.size() == 0, mq.size() == DEPTH, mq.size(), ovf, unf, m_mode);
  endtask

  initial begin
    logic [DW-1:0] last, val;
    logic [OW-1:0] exp;
    logic          rst, mi;
    logic [1:0]    op;
    int            r;

    reset   = 1'b1;
    mode_in = 1'b0;
    op_in   = 2'b00;
    data_in = '0;

    // Reset and idle
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // LIFO fill, overflow, drain, underflow
    for (int i = 1; i <= 8; i++) add(0, 0, 2, DW'(i), 0, 0, 0, i == 8, i, 0, 0, 0);
    add(0, 0, 2, 9, 0, 0, 0, 1, 8, 1, 0, 0);
    for (int i = 8; i >= 1; i--) add(0, 0, 1, 0, DW'(i), 1, i == 1, 0, i - 1, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0);
    // Push+pop bypass on empty, then on a full stack
    add(0, 0, 3, 8'h5A, 8'h5A, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(0, 0, 2, DW'(i), 8'h5A, 0, 0, i == 8, i, 0, 0, 0);
    add(0, 0, 3, 8'h77, 8, 1, 0, 1, 8, 0, 0, 0);
    add(0, 0, 1, 0, 8'h77, 1, 0, 0, 7, 0, 0, 0);
    for (int i = 7; i >= 1; i--) add(0, 0, 1, 0, DW'(i), 1, i == 1, 0, i - 1, 0, 0, 0);
    // Mode request ignored while non-empty, taken once drained
    add(0, 0, 2, 8'hA1, 1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 2, 8'hA2, 1, 0, 0, 0, 2, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0);
    add(0, 1, 1, 0, 8'hA2, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 8'hA1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'hA1, 0, 1, 0, 0, 0, 0, 1);
    // FIFO ordering
    add(0, 1, 2, 8'h0A, 8'hA1, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 2, 8'h0B, 8'hA1, 0, 0, 0, 2, 0, 0, 1);
    add(0, 1, 2, 8'h0C, 8'hA1, 0, 0, 0, 3, 0, 0, 1);
    add(0, 1, 1, 0, 8'h0A, 1, 0, 0, 2, 0, 0, 1);
    add(0, 1, 1, 0, 8'h0B, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 1, 0, 8'h0C, 1, 1, 0, 0, 0, 0, 1);
    // Repeated bursts carry the pointers across the wrap point
    last = 8'h0C;
    for (int rd = 0; rd < 3; rd++) begin
      for (int k = 0; k < 5; k++)
        add(0, 1, 2, DW'(8'h20 + rd * 5 + k), last, 0, 0, 0, k + 1, 0, 0, 1);
      for (int k = 0; k < 5; k++)
        add(0, 1, 1, 0, DW'(8'h20 + rd * 5 + k), 1, k == 4, 0, 4 - k, 0, 0, 1);
      last = DW'(8'h20 + rd * 5 + 4);
    end
    add(0, 1, 2, 8'h40, last, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 3, 8'h41, 8'h40, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 1, 0, 8'h41, 1, 1, 0, 0, 0, 0, 1);
    // Reset during the third push
    add(0, 0, 2, 8'h51, 8'h41, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 2, 8'h52, 8'h41, 0, 0, 0, 2, 0, 0, 0);
    add(1, 1, 2, 8'h53, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].mi, vecs[i].op, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Randomized traffic against the reference model
    model_step(1'b1, 1'b0, 2'b00, '0, exp);
    drive(1'b1, 1'b0, 2'b00, '0);
    check("rand_reset", exp);
    for (int phase = 0; phase < 4; phase++) begin
      for (int c = 0; c < 750; c++) begin
        rst = ($urandom_range(0, 199) == 0);
        mi  = 1'($urandom_range(0, 1));
        val = DW'($urandom);
        r   = $urandom_range(0, 9);
        if (phase[0] == 1'b0) op = (r < 5) ? 2'b10 : (r < 7) ? 2'b11 : (r < 9) ? 2'b01 : 2'b00;
        else                  op = (r < 5) ? 2'b01 : (r < 7) ? 2'b11 : (r < 9) ? 2'b10 : 2'b00;
        model_step(rst, mi, op, val, exp);
        drive(rst, mi, op, val);
        check($sformatf("rand_p%0d_c%0d", phase, c), exp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
